// File: rtl/gt_rx_pkg.sv
// Shared constants and FSM state encoding for the GT RX capture lane.
package gt_rx_pkg;

  localparam int GT_DATA_W = 32;
  localparam int GT_ADDR_W = 8;
  localparam int GT_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : gt_rx_pkg

// File: rtl/gt_rx_ram.sv
// Simple dual-port capture RAM: one write port, one read-first read port
// with a registered 1-cycle output and a matching valid strobe.
module gt_rx_ram
  import gt_rx_pkg::*;
#(
  parameter int DATA_W = GT_DATA_W,
  parameter int ADDR_W = GT_ADDR_W,
  parameter int DEPTH  = GT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined at power-up.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: non-blocking reads of mem see the pre-write value, giving read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule : gt_rx_ram

// File: rtl/gt_rx_capture.sv
// Per-lane GT RX capture: stores a programmable number of stream words into a
// local RAM after gt_start. Optional trigger-armed start with GT_RX_TRIG_EN.
module gt_rx_capture
  import gt_rx_pkg::*;
#(
  parameter int DATA_W = GT_DATA_W,
  parameter int ADDR_W = GT_ADDR_W,
  parameter int DEPTH  = GT_DEPTH
) (
  input  logic              gt_clk,
  input  logic              gt_rst,
  input  logic [DATA_W-1:0] gt_tdata,
  input  logic              gt_tvalid,
  output logic              gt_tready,
  input  logic [ADDR_W-1:0] gt_cap,
  input  logic              gt_start,
  input  logic              gt_reset,
`ifdef GT_RX_TRIG_EN
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
`endif
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_rd,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              ram_rvalid,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [ADDR_W:0]   cap_count
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   start_len;
  logic [ADDR_W:0]   count_inc;
  logic              accept;
  logic              trig_hit;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign gt_tready = (state == CAPT) || (state == ARM);
  assign cap_busy  = (state == CAPT) || (state == ARM);
  assign cap_done  = (state == DONE);

  assign start_len = (gt_cap == '0) ? FULL_LEN : {1'b0, gt_cap};
  assign count_inc = cap_count + 1'b1;
  assign accept    = gt_tvalid && gt_tready;

`ifdef GT_RX_TRIG_EN
  assign trig_hit = gt_tvalid && (((gt_tdata ^ trig_value) & trig_mask) == '0);
`else
  assign trig_hit = 1'b0;
`endif

  // A soft clear in the same cycle as a beat discards that beat, leaving RAM untouched.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    ram_we    = 1'b0;
    ram_waddr = cap_count[ADDR_W-1:0];
    ram_wdata = gt_tdata;
    if (!gt_reset) begin
      case (state)
        CAPT:    ram_we = accept;
        ARM: begin
          ram_we    = trig_hit;
          ram_waddr = '0;
        end
        default: ram_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge gt_clk or posedge gt_rst) begin
    if (gt_rst) begin
      state     <= IDLE;
      len       <= '0;
      cap_count <= '0;
    end else if (gt_reset) begin
      state     <= IDLE;
      cap_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (gt_start) begin
            len       <= start_len;
            cap_count <= '0;
`ifdef GT_RX_TRIG_EN
            state     <= ARM;
`else
            state     <= CAPT;
`endif
          end
        end
        CAPT: begin
          // len never exceeds DEPTH, so cap_count stops at len without wrapping.
          if (accept) begin
            cap_count <= count_inc;
            if (count_inc == len) state <= DONE;
          end
        end
`ifdef GT_RX_TRIG_EN
        ARM: begin
          if (trig_hit) begin
            cap_count <= {{ADDR_W{1'b0}}, 1'b1};
            state     <= (len == {{ADDR_W{1'b0}}, 1'b1}) ? DONE : CAPT;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  gt_rx_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (gt_clk),
    .rst    (gt_rst),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .re     (ram_rd),
    .raddr  (ram_addr),
    .rdata  (ram_rdata),
    .rvalid (ram_rvalid)
  );

endmodule : gt_rx_capture

// File: tb/tb_gt_rx_capture.sv
// Directed self-checking bench for gt_rx_capture; covers the trigger path
// when GT_RX_TRIG_EN is defined.
module tb_gt_rx_capture;

  logic        gt_clk = 1'b0;
  logic        gt_rst;
  logic [31:0] gt_tdata;
  logic        gt_tvalid;
  logic        gt_tready;
  logic [7:0]  gt_cap;
  logic        gt_start;
  logic        gt_reset;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [31:0] ram_rdata;
  logic        ram_rvalid;
  logic        cap_busy;
  logic        cap_done;
  logic [8:0]  cap_count;
`ifdef GT_RX_TRIG_EN
  logic [31:0] trig_value;
  logic [31:0] trig_mask;
`endif

  int tests = 0;
  int fails = 0;

  always #5 gt_clk = ~gt_clk;

  gt_rx_capture dut (
    .gt_clk     (gt_clk),
    .gt_rst     (gt_rst),
    .gt_tdata   (gt_tdata),
    .gt_tvalid  (gt_tvalid),
    .gt_tready  (gt_tready),
    .gt_cap     (gt_cap),
    .gt_start   (gt_start),
    .gt_reset   (gt_reset),
`ifdef GT_RX_TRIG_EN
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
`endif
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_rdata  (ram_rdata),
    .ram_rvalid (ram_rvalid),
    .cap_busy   (cap_busy),
    .cap_done   (cap_done),
    .cap_count  (cap_count)
  );

  task automatic tick();
    @(posedge gt_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One stream cycle; acc reports whether the beat completed a handshake.
  task automatic beat(input logic [31:0] d, input logic v, output bit acc);
    gt_tdata  = d;
    gt_tvalid = v;
    acc       = v && gt_tready;
    tick();
    gt_tvalid = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    gt_cap   = len;
    gt_start = 1'b1;
    tick();
    gt_start = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    ram_addr = a;
    ram_rd   = 1'b1;
    tick();
    ram_rd   = 1'b0;
    check({tag, "_rvalid"}, {63'd0, ram_rvalid}, 64'd1);
    check(tag, {32'd0, ram_rdata}, {32'd0, exp});
  endtask

  initial begin
    bit acc;
    int idx;
    int readies;

    gt_rst    = 1'b1;
    gt_tdata  = '0;
    gt_tvalid = 1'b0;
    gt_cap    = '0;
    gt_start  = 1'b0;
    gt_reset  = 1'b0;
    ram_addr  = '0;
    ram_rd    = 1'b0;
`ifdef GT_RX_TRIG_EN
    trig_value = '0;
    trig_mask  = '0;
`endif
    repeat (2) tick();
    gt_rst = 1'b0;
    tick();

    // Reset state
    check("rst_tready", {63'd0, gt_tready},  64'd0);
    check("rst_busy",   {63'd0, cap_busy},   64'd0);
    check("rst_done",   {63'd0, cap_done},   64'd0);
    check("rst_count",  {55'd0, cap_count},  64'd0);
    check("rst_rvalid", {63'd0, ram_rvalid}, 64'd0);
    check("rst_rdata",  {32'd0, ram_rdata},  64'd0);

    // Capture 4 words out of a continuous 0xA0..0xA7 stream
    pulse_start(8'd4);
    check("t1_busy",   {63'd0, cap_busy},  64'd1);
    check("t1_tready", {63'd0, gt_tready}, 64'd1);
    idx = 0;
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      beat(32'hA0 + 32'(idx), 1'b1, acc);
      if (acc) begin
        idx++;
        readies++;
      end
    end
    check("t1_ready_cycles", 64'(readies), 64'd4);
    check("t1_count",  {55'd0, cap_count}, 64'd4);
    check("t1_done",   {63'd0, cap_done},  64'd1);
    check("t1_busy_end", {63'd0, cap_busy}, 64'd0);
    check("t1_tready_end", {63'd0, gt_tready}, 64'd0);
    rd_check("t1_ram0", 8'd0, 32'hA0);
    rd_check("t1_ram1", 8'd1, 32'hA1);
    rd_check("t1_ram3", 8'd3, 32'hA3);
    tick();
    check("t1_rvalid_idle", {63'd0, ram_rvalid}, 64'd0);
    check("t1_rdata_hold",  {32'd0, ram_rdata},  64'hA3);

    // Full-depth capture (gt_cap=0) with tvalid on every other cycle
    pulse_start(8'd0);
    check("t2_done_cleared", {63'd0, cap_done}, 64'd0);
    idx = 0;
    for (int i = 0; i < 600; i++) begin
      beat(32'(idx), (i % 2 == 0) && (idx < 300), acc);
      if (acc) idx++;
    end
    check("t2_accepted", 64'(idx), 64'd256);
    check("t2_count",  {55'd0, cap_count}, 64'd256);
    check("t2_done",   {63'd0, cap_done},  64'd1);
    check("t2_tready", {63'd0, gt_tready}, 64'd0);
    rd_check("t2_ram0",   8'd0,   32'd0);
    rd_check("t2_ram128", 8'd128, 32'd128);
    rd_check("t2_ram255", 8'd255, 32'd255);

    // Soft clear mid-capture leaves stored words alone
    pulse_start(8'd8);
    for (int i = 0; i < 3; i++) beat(32'h300 + 32'(i), 1'b1, acc);
    check("t3_count_mid", {55'd0, cap_count}, 64'd3);
    gt_reset = 1'b1;
    beat(32'hBAD, 1'b1, acc);
    gt_reset = 1'b0;
    check("t3_count_clr", {55'd0, cap_count}, 64'd0);
    check("t3_done_clr",  {63'd0, cap_done},  64'd0);
    check("t3_busy_clr",  {63'd0, cap_busy},  64'd0);
    check("t3_tready_clr", {63'd0, gt_tready}, 64'd0);
    rd_check("t3_ram2", 8'd2, 32'h302);
    rd_check("t3_ram3", 8'd3, 32'd3);
    pulse_start(8'd2);
    for (int i = 0; i < 4; i++) beat(32'h400 + 32'(i), 1'b1, acc);
    check("t3_count2", {55'd0, cap_count}, 64'd2);
    check("t3_done2",  {63'd0, cap_done},  64'd1);
    rd_check("t3_ram0b", 8'd0, 32'h400);
    rd_check("t3_ram1b", 8'd1, 32'h401);
    rd_check("t3_ram2b", 8'd2, 32'h302);

    // gt_reset beats gt_start in the same cycle
    gt_reset = 1'b1;
    pulse_start(8'd5);
    gt_reset = 1'b0;
    check("t4_tready", {63'd0, gt_tready}, 64'd0);
    check("t4_busy",   {63'd0, cap_busy},  64'd0);
    check("t4_done",   {63'd0, cap_done},  64'd0);
    tick();
    check("t4_tready_hold", {63'd0, gt_tready}, 64'd0);

    // gt_start during a capture is ignored
    pulse_start(8'd5);
    beat(32'h500, 1'b1, acc);
    beat(32'h501, 1'b1, acc);
    gt_cap   = 8'd1;
    gt_start = 1'b1;
    beat(32'h502, 1'b1, acc);
    gt_start = 1'b0;
    check("t4_count_cont", {55'd0, cap_count}, 64'd3);
    check("t4_busy_cont",  {63'd0, cap_busy},  64'd1);
    for (int i = 3; i < 7; i++) beat(32'h500 + 32'(i), 1'b1, acc);
    check("t4_count_end", {55'd0, cap_count}, 64'd5);
    rd_check("t4_ram4", 8'd4, 32'h504);

    // Read-first: read address 0 in the cycle it is rewritten
    pulse_start(8'd2);
    ram_addr = 8'd0;
    ram_rd   = 1'b1;
    beat(32'h600, 1'b1, acc);
    ram_rd   = 1'b0;
    check("t5_rf_rvalid", {63'd0, ram_rvalid}, 64'd1);
    check("t5_rf_old",    {32'd0, ram_rdata},  64'h500);
    rd_check("t5_rf_new", 8'd0, 32'h600);
    rd_check("t5_stale",  8'd3, 32'h503);

`ifdef GT_RX_TRIG_EN
    // Trigger on the masked upper half-word
    beat(32'h601, 1'b1, acc);
    trig_value = 32'hDEAD_0000;
    trig_mask  = 32'hFFFF_0000;
    pulse_start(8'd3);
    beat(32'h1, 1'b1, acc);
    beat(32'h2, 1'b1, acc);
    check("t6_arm_count", {55'd0, cap_count}, 64'd0);
    check("t6_arm_busy",  {63'd0, cap_busy},  64'd1);
    beat(32'hDEAD_0005, 1'b1, acc);
    beat(32'h7, 1'b1, acc);
    beat(32'h8, 1'b1, acc);
    check("t6_count", {55'd0, cap_count}, 64'd3);
    check("t6_done",  {63'd0, cap_done},  64'd1);
    rd_check("t6_ram0", 8'd0, 32'hDEAD_0005);
    rd_check("t6_ram1", 8'd1, 32'h7);
    rd_check("t6_ram2", 8'd2, 32'h8);
    trig_mask = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_gt_rx_capture
